// File: rtl/rv_pipeline_n.sv
// Purpose: DEPTH-stage ready/valid pipeline adding INC per stage, with flush and live occupancy.
// Latency: DEPTH cycles stall-free; one word per cycle sustained throughput.
// Backpressure: combinational ready chain by default; with RV_PIPELINE_SKID_EN each stage is a
//   2-entry skid buffer with registered ready (capacity 2*DEPTH, no result_ready->data_ready path).
module rv_pipeline_n #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int INC   = 1
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [WIDTH-1:0]                 data,
   input  logic                             data_valid,
   output logic                             data_ready,
   output logic [WIDTH-1:0]                 result,
   output logic                             result_valid,
   input  logic                             result_ready,
   input  logic                             flush,
   output logic [$clog2(2*DEPTH+1)-1:0]     occupancy
);

   localparam int OW = $clog2(2*DEPTH+1);
   localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

   // Main register of each stage; stage DEPTH-1 drives the output.
   logic [DEPTH-1:0] vld;
   logic [WIDTH-1:0] dat [DEPTH];

   // What each stage sees from upstream: the input port for stage 0, the previous stage otherwise.
   logic [DEPTH-1:0] src_vld;
   logic [WIDTH-1:0] src_dat [DEPTH];

   // Route upstream valid/data into each stage.
   always_comb begin
      src_vld    = '0;
      src_vld[0] = data_valid;
      src_dat[0] = data;
      for (int k = 1; k < DEPTH; k++) begin
         src_vld[k] = vld[k-1];
         src_dat[k] = dat[k-1];
      end
   end

`ifdef RV_PIPELINE_SKID_EN
   // Second slot per stage catches the word already in flight when ready drops.
   logic [DEPTH-1:0] skid_vld;
   logic [WIDTH-1:0] skid_dat [DEPTH];

   // up_rdy[k] is stage k's registered ready to its upstream; up_rdy[DEPTH] is the consumer.
   logic [DEPTH:0]   up_rdy;
   logic [DEPTH-1:0] pop;
   logic [DEPTH-1:0] take;

   assign up_rdy = {result_ready, ~skid_vld};

   // A stage pops when its main word is taken downstream and takes when upstream offers into a free skid.
   always_comb begin
      pop  = '0;
      take = '0;
      for (int k = 0; k < DEPTH; k++) begin
         pop[k]  = vld[k] && up_rdy[k+1];
         take[k] = src_vld[k] && up_rdy[k];
      end
   end

   // Skid stage update: refill main from skid first so order is kept, otherwise load new words.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld      <= '0;
         skid_vld <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            dat[k]      <= '0;
            skid_dat[k] <= '0;
         end
      end else if (flush) begin
         vld      <= '0;
         skid_vld <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (pop[k] && skid_vld[k]) begin
               dat[k]      <= skid_dat[k];
               skid_vld[k] <= 1'b0;
            end else if (pop[k] || !vld[k]) begin
               vld[k] <= take[k];
               if (take[k]) dat[k] <= src_dat[k] + INC_W;
            end else if (take[k]) begin
               skid_vld[k] <= 1'b1;
               skid_dat[k] <= src_dat[k] + INC_W;
            end
         end
      end
   end

   assign data_ready = !flush && !reset && up_rdy[0];
`else
   // rdy[k]: stage k can load this cycle; rdy[DEPTH] is the consumer.
   logic [DEPTH:0] rdy;

   // Ready ripples back from the consumer: a stage is free if empty or its word moves on.
   always_comb begin
      rdy        = '0;
      rdy[DEPTH] = result_ready;
      for (int k = DEPTH-1; k >= 0; k--) begin
         rdy[k] = !vld[k] || rdy[k+1];
      end
   end

   // Single-register stage update: load (and increment) whenever the stage is free to advance.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            dat[k] <= '0;
         end
      end else if (flush) begin
         vld <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (rdy[k]) begin
               vld[k] <= src_vld[k];
               if (src_vld[k]) dat[k] <= src_dat[k] + INC_W;
            end
         end
      end
   end

   assign data_ready = !flush && !reset && rdy[0];
`endif

   assign result       = dat[DEPTH-1];
   assign result_valid = vld[DEPTH-1] && !flush;

   logic acc_xfer;
   logic emit_xfer;

   assign acc_xfer  = data_valid && data_ready;
   assign emit_xfer = result_valid && result_ready;

   // Occupancy tracks accepted-but-not-emitted words; flush and reset empty it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         occupancy <= '0;
      end else if (flush) begin
         occupancy <= '0;
      end else if (acc_xfer && !emit_xfer) begin
         occupancy <= occupancy + OW'(1);
      end else if (!acc_xfer && emit_xfer) begin
         occupancy <= occupancy - OW'(1);
      end
   end

endmodule

// File: tb/tb_rv_pipeline_n.sv
// Bench for rv_pipeline_n: directed table vectors plus randomized traffic against a queue model.
// Model: each accepted word is expected back as word + DEPTH*INC, in order; flush/reset empty it.
// A second instance with WIDTH=8 covers narrow-width wrap.
module tb_rv_pipeline_n;
   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
   localparam int INC   = 1;
`ifdef RV_PIPELINE_SKID_EN
   localparam int CAP = 2*DEPTH;
`else
   localparam int CAP = DEPTH;
`endif
   localparam int OW  = $clog2(2*DEPTH+1);

   logic             clock, reset;
   logic [WIDTH-1:0] data, result;
   logic             data_valid, data_ready, result_valid, result_ready, flush;
   logic [OW-1:0]    occupancy;

   logic [7:0]       d8, r8;
   logic             v8, rdy8, r8v, r8r, f8;
   logic [OW-1:0]    occ8;

   rv_pipeline_n #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INC(INC)) u_dut (
      .clock(clock), .reset(reset), .data(data), .data_valid(data_valid), .data_ready(data_ready),
      .result(result), .result_valid(result_valid), .result_ready(result_ready),
      .flush(flush), .occupancy(occupancy));

   rv_pipeline_n #(.WIDTH(8), .DEPTH(DEPTH), .INC(INC)) u_dut8 (
      .clock(clock), .reset(reset), .data(d8), .data_valid(v8), .data_ready(rdy8),
      .result(r8), .result_valid(r8v), .result_ready(r8r),
      .flush(f8), .occupancy(occ8));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct { logic [15:0] din; logic [15:0] dout; } vec16_t;
   typedef struct { logic [7:0]  din; logic [7:0]  dout; } vec8_t;

   int checks = 0;
   int failures = 0;
   int win = 0;

   logic [15:0] q[$];
   logic [15:0] got[$];
   logic [7:0]  got8[$];
   int          got_win[$];
   int          acc_win[$];

   logic last_acc, last_em, last_drdy, last_rvld, last_acc8;
   logic [OW-1:0] last_occ;
   logic [15:0] v;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (window %0d)", name, act, exp, win);
      end
   endtask

   // One cycle: sample at the falling edge, check against the model, update it, then advance.
   task automatic tick();
      logic [15:0] e;
      logic        exp_rdy;
      @(negedge clock);
      last_acc  = data_valid && data_ready;
      last_em   = result_valid && result_ready;
      last_drdy = data_ready;
      last_rvld = result_valid;
      last_occ  = occupancy;
      last_acc8 = v8 && rdy8;
      check("occupancy", 32'(occupancy), 32'(q.size()));
      if (flush) begin
         check("flush_data_ready", 32'(data_ready), 0);
         check("flush_result_valid", 32'(result_valid), 0);
      end
`ifndef RV_PIPELINE_SKID_EN
      exp_rdy = !flush && !reset && !(q.size() == DEPTH && !result_ready);
      check("ready_rule", 32'(data_ready), 32'(exp_rdy));
`endif
      if (result_valid)
         check("result_vs_model", 32'(result), (q.size() > 0) ? 32'(q[0]) : 32'hDEADBEEF);
      if (last_em && q.size() > 0) begin
         void'(q.pop_front());
         got.push_back(result);
         got_win.push_back(win);
      end
      if (last_acc) begin
         e = data + 16'(DEPTH*INC);
         q.push_back(e);
         acc_win.push_back(win);
      end
      if (flush) q.delete();
      if (r8v && r8r) got8.push_back(r8);
      @(posedge clock);
      #1;
      win++;
   endtask

   // Keep the pending word offered until accepted, then drop valid.
   task automatic finish_pending(input string name);
      for (int c = 0; c < 4*CAP + 4 && data_valid; c++) begin
         tick();
         if (last_acc) data_valid = 1'b0;
      end
      check(name, 32'(data_valid), 0);
      data_valid = 1'b0;
   endtask

   vec16_t t1[13];
   vec8_t  t8[3];
   int     n_acc;

   initial begin
      for (int i = 0; i < 10; i++) t1[i] = '{16'(i), 16'(i + 4)};
      t1[10] = '{16'hFFFD, 16'h0001};
      t1[11] = '{16'hFFFE, 16'h0002};
      t1[12] = '{16'hFFFF, 16'h0003};
      t8[0]  = '{8'hFD, 8'h01};
      t8[1]  = '{8'hFE, 8'h02};
      t8[2]  = '{8'hFF, 8'h03};

      reset = 1'b1; flush = 1'b0; data = '0; data_valid = 1'b0; result_ready = 1'b0;
      d8 = '0; v8 = 1'b0; r8r = 1'b1; f8 = 1'b0;

      // Reset state
      #12;
      check("rst_data_ready", 32'(data_ready), 0);
      check("rst_result_valid", 32'(result_valid), 0);
      check("rst_result", 32'(result), 0);
      check("rst_occupancy", 32'(occupancy), 0);
      @(posedge clock); #1;
      reset = 1'b0;
      tick();
      check("rst_release_ready", 32'(last_drdy), 1);

      // Test 1: stream table with consumer always ready
      result_ready = 1'b1;
      got.delete(); got_win.delete(); acc_win.delete();
      for (int i = 0; i < 13; i++) begin
         data = t1[i].din; data_valid = 1'b1;
         tick();
         check("t1_accept", 32'(last_acc), 1);
      end
      data_valid = 1'b0;
      repeat (8) tick();
      check("t1_count", 32'(got.size()), 13);
      for (int i = 0; i < 13 && i < got.size(); i++) begin
         check("t1_result", 32'(got[i]), 32'(t1[i].dout));
         if (i > 0) check("t1_gap", 32'(got_win[i] - got_win[i-1]), 1);
      end
      if (got_win.size() > 0 && acc_win.size() > 0)
         check("t1_latency", 32'(got_win[0] - acc_win[0]), DEPTH);

      // Test 2: 8-bit wrap
      got8.delete();
      for (int i = 0; i < 3; i++) begin
         d8 = t8[i].din; v8 = 1'b1;
         tick();
         check("t2_accept8", 32'(last_acc8), 1);
      end
      v8 = 1'b0;
      repeat (6) tick();
      check("t2_count8", 32'(got8.size()), 3);
      for (int i = 0; i < 3 && i < got8.size(); i++)
         check("t2_result8", 32'(got8[i]), 32'(t8[i].dout));

      // Test 3: stall fills to capacity, then drain
      got.delete();
      result_ready = 1'b0; n_acc = 0; v = 16'd200;
      data = v; data_valid = 1'b1;
      for (int c = 0; c < 2*CAP + 4; c++) begin
         tick();
         if (last_acc) begin n_acc++; v++; data = v; end
      end
      check("t3_accepts", 32'(n_acc), CAP);
      check("t3_ready_low", 32'(last_drdy), 0);
      check("t3_occ_full", 32'(last_occ), CAP);
      result_ready = 1'b1;
      finish_pending("t3_pending");
      repeat (3*CAP) tick();
      check("t3_drained", 32'(q.size()), 0);
      check("t3_emitted", 32'(got.size()), CAP + 1);

      // Test 4: full pipe with consumer toggling
      result_ready = 1'b0; v = 16'd300; data = v; data_valid = 1'b1;
      for (int c = 0; c < 4*CAP && last_drdy; c++) begin
         tick();
         if (last_acc) begin v++; data = v; end
      end
      check("t4_full", 32'(q.size()), CAP);
      for (int c = 0; c < 8; c++) begin
         result_ready = (c % 2 == 0);
         tick();
         check("t4_emit", 32'(last_em), 32'(result_ready));
`ifndef RV_PIPELINE_SKID_EN
         check("t4_accept", 32'(last_acc), 32'(result_ready));
`endif
         check("t4_cap", 32'(last_occ <= CAP), 1);
         if (last_acc) begin v++; data = v; end
      end
      result_ready = 1'b1;
      finish_pending("t4_pending");
      repeat (3*CAP) tick();
      check("t4_drained", 32'(q.size()), 0);

      // Test 5: flush with 3 words held
      result_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         data = 16'(50 + i); data_valid = 1'b1;
         tick();
         check("t5_accept", 32'(last_acc), 1);
      end
      data = 16'd53; flush = 1'b1;
      tick();
      check("t5_flush_ready", 32'(last_drdy), 0);
      check("t5_flush_valid", 32'(last_rvld), 0);
      flush = 1'b0; data = 16'd20; result_ready = 1'b1;
      got.delete();
      tick();
      check("t5_occ_zero", 32'(last_occ), 0);
      if (last_acc) data_valid = 1'b0;
      finish_pending("t5_pending");
      repeat (8) tick();
      check("t5_count", 32'(got.size()), 1);
      if (got.size() > 0) check("t5_result", 32'(got[0]), 24);

      // Test 6: asynchronous reset mid-stream
      v = 16'd30; data = v; data_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (last_acc) begin v++; data = v; end
      end
      @(posedge clock); #3;
      reset = 1'b1;
      #1;
      check("t6_result_valid", 32'(result_valid), 0);
      check("t6_data_ready", 32'(data_ready), 0);
      check("t6_occupancy", 32'(occupancy), 0);
      q.delete(); got.delete();
      data_valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         data = 16'(100 + i); data_valid = 1'b1;
         tick();
         check("t6_accept", 32'(last_acc), 1);
      end
      data_valid = 1'b0;
      repeat (8) tick();
      check("t6_count", 32'(got.size()), 10);
      for (int i = 0; i < 10 && i < got.size(); i++)
         check("t6_result", 32'(got[i]), 32'(104 + i));

      // Randomized traffic with occasional flush
      data_valid = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         if (!data_valid || last_acc) begin
            data_valid = ($urandom_range(0, 3) != 0);
            data = 16'($urandom);
         end
         result_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 59) == 0);
         tick();
      end
      flush = 1'b0; result_ready = 1'b1;
      if (last_acc) data_valid = 1'b0;
      finish_pending("rand_pending");
      repeat (3*CAP) tick();
      check("rand_drained", 32'(q.size()), 0);
      check("rand_occupancy", 32'(occupancy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
